// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv feature-map path.
// Derived sizes are functions so each instance can compute them from its own parameters.
package cnn_pkg;

    localparam int ROW_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } fm_state_t;

    function automatic int calc_oh(input int h, input int f);
        return h - f + 1;
    endfunction

    function automatic int calc_ow(input int w, input int f);
        return w - f + 1;
    endfunction

    function automatic int calc_half(input int w, input int f);
        return (w - f + 1) / 2;
    endfunction

    // One spare bit so row*OW + offset can never wrap.
    function automatic int calc_idx_w(input int oh, input int ow);
        return $clog2(oh * ow) + 1;
    endfunction

endpackage

// File: rtl/fm_row_col_sequencer.sv
// Row / half-row position counter that walks an OH x 2 chunk grid.
// Reusable by both the read-side selector and the write-side assembler.
module fm_row_col_sequencer
    import cnn_pkg::*;
#(
    parameter int OH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row_number,
    output logic             column,
    output logic             last_chunk
);

    logic [ROW_W-1:0] row_q, row_d;
    logic             col_q, col_d;

    assign last_chunk = (row_q == ROW_W'(OH - 1)) && col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = 1'b0;
        end else if (advance) begin
            // The final chunk returns to origin instead of stepping past OH-1.
            if (last_chunk) begin
                row_d = '0;
                col_d = 1'b0;
            end else begin
                col_d = ~col_q;
                if (col_q) begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_number = row_q;
    assign column     = col_q;

endmodule

// File: rtl/feature_map_assembler.sv
// Assembles half-row conv chunks into a registered output feature map.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   COLLECT | accepting chunks in row-major half-row order
//   DONE    | map complete and held, waiting for start
module feature_map_assembler
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int H          = 16,
    parameter int W          = 16,
    parameter int F          = 5
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [0:calc_half(W, F)*DATA_WIDTH-1]             in_data,
    output logic [ROW_W-1:0]                                  row_number,
    output logic                                              column,
    output logic [0:calc_oh(H, F)*calc_ow(W, F)*DATA_WIDTH-1] out_map,
    output logic                                              map_valid,
    output logic                                              done
);

    localparam int OH     = calc_oh(H, F);
    localparam int OW     = calc_ow(W, F);
    localparam int HALF   = calc_half(W, F);
    localparam int IDX_W  = calc_idx_w(OH, OW);
    localparam int MAP_W  = OH * OW * DATA_WIDTH;

    localparam logic [IDX_W-1:0] OW_I   = IDX_W'(OW);
    localparam logic [IDX_W-1:0] HALF_I = IDX_W'(HALF);

    fm_state_t state_q, state_d;

    logic             start_go;
    logic             accept;
    logic             last_chunk;
    logic             last_accept;
    logic [IDX_W-1:0] wr_base;

    logic [0:MAP_W-1] out_map_q, out_map_d;
    logic             map_valid_q, map_valid_d;
    logic             done_q, done_d;

    fm_row_col_sequencer #(
        .OH (OH)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_go),
        .advance    (accept),
        .row_number (row_number),
        .column     (column),
        .last_chunk (last_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = COLLECT;
            COLLECT: if (last_accept) state_d = DONE;
            DONE:    if (start)       state_d = COLLECT;
            default:                  state_d = IDLE;
        endcase
    end

    // Ready is a pure state decode; start only matters outside COLLECT.
    always_comb begin
        in_ready    = (state_q == COLLECT);
        start_go    = start && ((state_q == IDLE) || (state_q == DONE));
        accept      = in_valid && in_ready;
        last_accept = accept && last_chunk;
    end

    assign wr_base = IDX_W'(row_number) * OW_I + (column ? HALF_I : '0);

    always_comb begin
        out_map_d = out_map_q;
        if (start_go) begin
            out_map_d = '0;
        end else if (accept) begin
            for (int j = 0; j < HALF; j++) begin
                out_map_d[int'(wr_base + IDX_W'(j)) * DATA_WIDTH +: DATA_WIDTH] =
                    in_data[j * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        map_valid_d = map_valid_q;
        if (start_go) begin
            map_valid_d = 1'b0;
        end else if (last_accept) begin
            map_valid_d = 1'b1;
        end
        done_d = last_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_map_q   <= '0;
            map_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_map_q   <= out_map_d;
            map_valid_q <= map_valid_d;
            done_q      <= done_d;
        end
    end

    assign out_map   = out_map_q;
    assign map_valid = map_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_feature_map_assembler.sv
// Directed, table-driven bench for feature_map_assembler at default parameters.
module tb_feature_map_assembler;

    localparam int DW   = 4;
    localparam int OH   = 12;
    localparam int OW   = 12;
    localparam int HALF = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic [0:HALF*DW-1]    in_data = '0;
    logic                  in_ready;
    logic [5:0]            row_number;
    logic                  column;
    logic [0:OH*OW*DW-1]   out_map;
    logic                  map_valid;
    logic                  done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       st;
        logic       v;
        logic [3:0] val;
        logic       e_ready;
        logic [5:0] e_row;
        logic       e_col;
        logic       e_done;
        logic       e_mv;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    feature_map_assembler #(
        .DATA_WIDTH (4),
        .H          (16),
        .W          (16),
        .F          (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .row_number (row_number),
        .column     (column),
        .out_map    (out_map),
        .map_valid  (map_valid),
        .done       (done)
    );

    task automatic drive(input logic st, input logic v, input logic [3:0] val);
        @(negedge clk);
        start    = st;
        in_valid = v;
        for (int j = 0; j < HALF; j++) in_data[j*DW +: DW] = val;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {in_ready, row_number, column, done, map_valid}
    function automatic logic [9:0] ctl_now();
        return {in_ready, row_number, column, done, map_valid};
    endfunction

    function automatic logic [3:0] chunk_val(input int mode, input int k);
        case (mode)
            0:       return 4'(k % 16);
            1:       return 4'hA;
            default: return ((k == 1) || (k == 22)) ? 4'h3 : 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] exp_pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 4'((2*r + ((c >= 6) ? 1 : 0)) % 16);
            1:       return 4'hA;
            default: return (((r == 0) && (c >= 6)) || ((r == 11) && (c < 6))) ? 4'h3 : 4'h0;
        endcase
    endfunction

    // Entry 0 is the start (with a stray valid chunk that must be ignored),
    // then 24 chunks, optionally separated by idle gaps, then one ignored chunk in DONE.
    task automatic build(input int mode, input int gap, input int restart_at);
        vec_t e;
        tbl.delete();
        e.st = 1'b1; e.v = 1'b1; e.val = 4'hF;
        e.e_ready = 1'b1; e.e_row = 6'd0; e.e_col = 1'b0; e.e_done = 1'b0; e.e_mv = 1'b0;
        tbl.push_back(e);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    e.st = 1'b0; e.v = 1'b0; e.val = 4'h0;
                    e.e_ready = 1'b1; e.e_row = 6'(k/2); e.e_col = 1'(k%2);
                    e.e_done = 1'b0; e.e_mv = 1'b0;
                    tbl.push_back(e);
                end
            end
            e.st = (k == restart_at); e.v = 1'b1; e.val = chunk_val(mode, k);
            if (k < 23) begin
                e.e_ready = 1'b1; e.e_row = 6'((k+1)/2); e.e_col = 1'((k+1)%2);
                e.e_done = 1'b0; e.e_mv = 1'b0;
            end else begin
                e.e_ready = 1'b0; e.e_row = 6'd0; e.e_col = 1'b0;
                e.e_done = 1'b1; e.e_mv = 1'b1;
            end
            tbl.push_back(e);
        end
        e.st = 1'b0; e.v = 1'b1; e.val = 4'hF;
        e.e_ready = 1'b0; e.e_row = 6'd0; e.e_col = 1'b0; e.e_done = 1'b0; e.e_mv = 1'b1;
        tbl.push_back(e);
    endtask

    task automatic run_table(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].val);
            check($sformatf("%s step %0d ctl", tag, i), 64'(ctl_now()),
                  64'({tbl[i].e_ready, tbl[i].e_row, tbl[i].e_col, tbl[i].e_done, tbl[i].e_mv}));
            if (i == 0) check($sformatf("%s map cleared on start", tag), 64'(|out_map), 64'd0);
        end
    endtask

    task automatic check_map(input string tag, input int mode);
        int bad = 0;
        int fr = 0, fc = 0;
        logic [3:0] fgot = '0, fexp = '0;
        logic [3:0] got;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                got = out_map[(r*OW + c)*DW +: DW];
                if (got !== exp_pix(mode, r, c)) begin
                    if (bad == 0) begin
                        fr = r; fc = c; fgot = got; fexp = exp_pix(mode, r, c);
                    end
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL map %s: %0d wrong pixels, first (%0d,%0d) got %0h expected %0h",
                     tag, bad, fr, fc, fgot, fexp);
        end
    endtask

    initial begin
        #3;
        check("reset ctl", 64'(ctl_now()), 64'd0);
        check("reset map", 64'(|out_map), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b0, 1'b1, 4'hF);
        drive(1'b0, 1'b1, 4'hF);
        check("idle valid ignored ctl", 64'(ctl_now()), 64'd0);
        check("idle valid ignored map", 64'(|out_map), 64'd0);

        build(0, 0, -1);
        run_table("cont", 0, tbl.size() - 1);
        check_map("cont", 0);

        drive(1'b0, 1'b1, 4'hF);
        drive(1'b0, 1'b1, 4'hF);
        check("done hold ctl", 64'(ctl_now()), 64'({1'b0, 6'd0, 1'b0, 1'b0, 1'b1}));
        check_map("done valid ignored", 0);

        build(0, 2, -1);
        run_table("gaps", 0, tbl.size() - 1);
        check_map("gaps", 0);

        build(1, 0, 5);
        run_table("restart", 0, tbl.size() - 1);
        check_map("restart", 1);

        build(0, 0, -1);
        run_table("abort", 0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort async ctl", 64'(ctl_now()), 64'd0);
        check("abort async map", 64'(|out_map), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 4'h7);
        check("abort stays idle", 64'(ctl_now()), 64'd0);
        run_table("after_abort", 0, tbl.size() - 1);
        check_map("after_abort", 0);

        build(2, 0, -1);
        run_table("boundary", 0, tbl.size() - 1);
        check_map("boundary", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
